// File: rtl/des_out_serializer.sv
// des_out_serializer: buffers 64-bit cipher blocks in a small FIFO and streams
// each one out MSB-first as 8 bytes over a valid/ready interface.
module des_out_serializer #(
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       blk_in,
   input  logic              blk_valid,
   output logic [7:0]        byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_last,
   output logic [ADDR_W:0]   fifo_count,
   output logic              overflow,
   input  logic              ovf_clr,
   output logic              busy
);
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t            state;
   logic [63:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [63:0]       shreg;
   logic [2:0]        idx;
   logic              pop, push;
   // A pop on the final accepted byte frees a slot, so a full FIFO can still take a block
   assign pop  = (fifo_count != '0) && (state == IDLE || (byte_ready && idx == 3'd7));
   assign push = blk_valid && (fifo_count < (ADDR_W + 1)'(DEPTH) || pop);
   assign byte_valid = (state == SHIFT);
   assign byte_out   = byte_valid ? shreg[63:56] : 8'h00;
   assign byte_last  = byte_valid && idx == 3'd7;
   assign busy       = byte_valid || fifo_count != '0;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= blk_in;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         shreg      <= '0;
         idx        <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
         if (push && !pop) fifo_count <= fifo_count + (ADDR_W + 1)'(1);
         else if (pop && !push) fifo_count <= fifo_count - (ADDR_W + 1)'(1);
         overflow <= (blk_valid && !push) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
         if (pop) begin
            shreg <= mem[rd_ptr];
            idx   <= 3'd0;
            state <= SHIFT;
         end else if (state == SHIFT && byte_ready) begin
            shreg <= shreg << 8;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_des_out_serializer.sv
// tb_des_out_serializer: directed scoreboard bench for the block-to-byte serializer.
module tb_des_out_serializer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] blk_in = '0;
   logic        blk_valid = 1'b0;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready = 1'b0;
   logic        byte_last;
   logic [2:0]  fifo_count;
   logic        overflow;
   logic        ovf_clr = 1'b0;
   logic        busy;

   int          n_assert = 0;
   int          n_fail = 0;
   logic [7:0]  exp_q[$];
   bit          last_q[$];
   bit          hold_pending = 0;
   logic [7:0]  held = '0;
   logic [63:0] blks [6];

   des_out_serializer #(.ADDR_W(2)) dut (
      .clk(clk), .rst(rst), .blk_in(blk_in), .blk_valid(blk_valid),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .byte_last(byte_last), .fifo_count(fifo_count), .overflow(overflow),
      .ovf_clr(ovf_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_blk(input logic [63:0] b);
      for (int i = 7; i >= 0; i--) begin
         exp_q.push_back(b[i*8 +: 8]);
         last_q.push_back(i == 0);
      end
   endtask

   // One clock: check the handshake at the falling edge, then return just after the rising edge
   task automatic cyc();
      @(negedge clk);
      if (hold_pending) begin
         chk("hold_valid", 64'(byte_valid), 1);
         chk("hold_byte", 64'(byte_out), 64'(held));
      end
      if (!byte_valid) chk("idle_zero", {byte_out, byte_last}, 0);
      if (byte_valid && byte_ready) begin
         chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            chk("byte", 64'(byte_out), 64'(exp_q.pop_front()));
            chk("last", 64'(byte_last), 64'(last_q.pop_front()));
         end
      end
      hold_pending = byte_valid && !byte_ready;
      held = byte_out;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [63:0] b, input bit accepted);
      blk_in = b;
      blk_valid = 1'b1;
      if (accepted) exp_blk(b);
      cyc();
      blk_valid = 1'b0;
   endtask

   task automatic drain(input int max);
      int k = 0;
      while (exp_q.size() != 0 && k < max) begin
         cyc();
         k++;
      end
      chk("drain_empty", 64'(exp_q.size()), 0);
   endtask

   initial begin
      for (int i = 0; i < 6; i++) blks[i] = {$urandom, $urandom};
      #1;
      chk("rst_async", {byte_out, byte_valid, byte_last, overflow, busy, fifo_count}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_state", {byte_out, byte_valid, byte_last, overflow, busy, fifo_count}, 0);

      // Single block, consumer always ready
      byte_ready = 1'b1;
      pulse(64'h0123456789ABCDEF, 1);
      chk("lat_count1", 64'(fifo_count), 1);
      chk("lat_valid0", 64'(byte_valid), 0);
      cyc();
      chk("lat_valid1", 64'(byte_valid), 1);
      chk("lat_count0", 64'(fifo_count), 0);
      chk("first_byte", 64'(byte_out), 64'h01);
      for (int k = 0; k < 8; k++) begin
         chk("single_contig", 64'(byte_valid), 1);
         cyc();
      end
      chk("single_empty", 64'(exp_q.size()), 0);
      chk("busy_fall", 64'(busy), 0);

      // Backpressure: ready alternates 1/0, 8 bytes take 15 cycles
      pulse(64'h0123456789ABCDEF, 1);
      cyc();
      for (int k = 0; k < 15; k++) begin
         byte_ready = (k % 2 == 0);
         cyc();
      end
      chk("bp_empty", 64'(exp_q.size()), 0);
      chk("bp_done", 64'(byte_valid), 0);

      // Burst of 5 with ready low: 4 queued plus 1 in the shifter
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) pulse(blks[i], 1);
      chk("burst_count", 64'(fifo_count), 4);
      chk("burst_ovf", 64'(overflow), 0);
      chk("burst_head", 64'(byte_out), 64'(blks[0][63:56]));
      byte_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         chk("burst_contig", 64'(byte_valid), 1);
         cyc();
      end
      chk("burst_empty", 64'(exp_q.size()), 0);
      chk("burst_idle", 64'(busy), 0);

      // Overflow: the 6th pulse is dropped
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) pulse(blks[5 - i], 1);
      chk("pre_ovf", 64'(overflow), 0);
      pulse(64'hDEADBEEFDEADBEEF, 0);
      chk("ovf_set", 64'(overflow), 1);
      chk("ovf_count", 64'(fifo_count), 4);
      ovf_clr = 1'b1;
      cyc();
      ovf_clr = 1'b0;
      chk("ovf_clr", 64'(overflow), 0);
      ovf_clr = 1'b1;
      pulse(64'hBADBADBADBADBAD0, 0);
      ovf_clr = 1'b0;
      chk("ovf_prio", 64'(overflow), 1);
      ovf_clr = 1'b1;
      cyc();
      ovf_clr = 1'b0;
      chk("ovf_clr2", 64'(overflow), 0);
      byte_ready = 1'b1;
      drain(60);

      // Full FIFO accepts a block when the last byte is taken in the same cycle
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) pulse(blks[i] ^ 64'hFFFF, 1);
      chk("full_count", 64'(fifo_count), 4);
      byte_ready = 1'b1;
      repeat (7) cyc();
      chk("full_last", 64'(byte_last), 1);
      pulse(64'hFEDCBA9876543210, 1);
      chk("full_pop_count", 64'(fifo_count), 4);
      chk("full_pop_ovf", 64'(overflow), 0);
      drain(60);

      // Reset mid-stream abandons the active and queued blocks
      pulse(64'h1122334455667788, 1);
      pulse(64'h99AABBCCDDEEFF00, 1);
      repeat (3) cyc();
      chk("mid_valid", 64'(byte_valid), 1);
      chk("mid_count", 64'(fifo_count), 1);
      chk("mid_byte", 64'(byte_out), 64'h44);
      exp_q.delete();
      last_q.delete();
      rst = 1'b1;
      #2;
      chk("mid_rst", {byte_out, byte_valid, byte_last, overflow, busy, fifo_count}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold_pending = 0;
      pulse(64'hA1B2C3D4E5F60718, 1);
      cyc();
      chk("post_rst_first", 64'(byte_out), 64'hA1);
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/des_out_serializer.md
# des_out_serializer

Downstream of the cipher's 64-bit output register: captures each finished ciphertext block (presented with a single-cycle valid pulse and no backpressure) into a small FIFO. It then streams each block out as 8 bytes, MSB first, over a valid/ready byte interface. This decouples the fixed-rate cipher core from a slower or stalling consumer (UART/SPI/bus bridge) and flags any block lost to overflow.

## Interface
- ADDR_W, 2, FIFO address width; depth DEPTH = 2**ADDR_W blocks (default 4)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- blk_in  input  64  ciphertext block from output register
- blk_valid  input  1  single-cycle pulse; blk_in valid this cycle
- byte_out  output  8  current byte to consumer
- byte_valid  output  1  byte_out valid
- byte_ready  input  1  consumer accepts byte_out this cycle
- byte_last  output  1  high with the 8th (final) byte of a block
- fifo_count  output  ADDR_W+1  blocks waiting in FIFO (excludes block being shifted)
- overflow  output  1  sticky: a block was dropped
- ovf_clr  input  1  synchronous clear of overflow
- busy  output  1  byte_valid | (fifo_count != 0)

## Operation
- FIFO: DEPTH x 64, circular rd/wr pointers (ADDR_W bits, natural wrap), count register ADDR_W+1 bits.
- Push when blk_valid and (fifo_count < DEPTH or pop this cycle). Push when full without simultaneous pop: block discarded, pointers/count unchanged, overflow <= 1.
- Pop occurs when serializer loads a new block (see FSM). Simultaneous push+pop: count unchanged, both pointers advance.
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.
- FSM states IDLE, SHIFT:
  - IDLE: byte_valid=0. If fifo_count != 0: pop head into 64-bit shift register, byte index <= 0, go SHIFT.
  - SHIFT: byte_valid=1, byte_out = shreg[63:56], byte_last = (index == 7). On byte_ready: shreg <<= 8, index++. On byte_ready with index==7: if fifo_count != 0 pop next block directly (remain SHIFT, index <= 0, no bubble), else go IDLE.
  - Without byte_ready, byte_out/byte_valid/byte_last held stable indefinitely.
- Byte order: blk_in[63:56] first, blk_in[7:0] last.
- byte_out and byte_last are 0 whenever byte_valid=0.

## Timing
- Reset values: byte_out=0, byte_valid=0, byte_last=0, fifo_count=0, overflow=0, busy=0, FSM=IDLE, pointers=0. Reset mid-stream abandons the current block and all queued blocks immediately.
- Latency: blk_valid in cycle N (empty FIFO, IDLE) -> fifo_count=1 in N+1 -> byte_valid=1 with first byte in N+2, fifo_count back to 0 in N+2.
- With byte_ready held high: one byte per cycle; back-to-back queued blocks give 8k contiguous valid cycles, no idle gap.
- Throughput bound: sustainable input is one block per 8 cycles; faster bursts absorbed up to DEPTH queued plus 1 in the shift register.
- overflow visible the cycle after the dropped pulse.

## Test plan
- Single block 0x0123456789ABCDEF, byte_ready=1 -> bytes 01,23,45,67,89,AB,CD,EF in cycles N+2..N+9, byte_last only on EF, busy falls after EF.
- Backpressure: same block, byte_ready toggled 1/0 each cycle -> each byte held stable while ready=0; sequence identical; 15 cycles total for 8 bytes.
- Burst: 5 pulses on consecutive cycles (blocks B0..B4), byte_ready=0 until all pushed -> fifo_count peaks at 4 with B0 in shifter, overflow=0; then ready=1 yields 40 contiguous bytes in order.
- Overflow: ready=0, 6 consecutive pulses -> 6th block dropped, overflow=1 next cycle; ovf_clr pulse -> overflow=0; ovf_clr coincident with another drop -> overflow stays 1.
- Full with simultaneous pop: FIFO full, ready=1 on last byte of shifter block in same cycle as new pulse -> block accepted, fifo_count stays 4, overflow stays 0, pointer wrap verified by order.
- Reset mid-stream after byte 3 -> all outputs 0 asynchronously; next block after release starts from its first byte.
